// File: rtl/soc_network_adapter_pkg.sv
// Shared types and constants for the network adapter Wishbone bus bridge:
// FSM state encoding, Wishbone cycle-type codes and downstream region indices.
package soc_network_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned REGION_CONF     = 0;
  localparam int unsigned REGION_MPSIMPLE = 1;
  localparam int unsigned REGION_DMA      = 2;

  function automatic logic [1:0] region_of(input logic [15:0] adr);
    return adr[15:14];
  endfunction

endpackage

// File: rtl/soc_network_adapter_watchdog.sv
// Saturating 8-bit ACCESS-cycle counter for the bus bridge; flags expiry during
// the TIMEOUT-th consecutive enabled cycle.
module soc_network_adapter_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // r_count holds the number of completed ACCESS cycles, so the current cycle is r_count+1.
  assign o_expired = i_enable && ((32'(r_count) + 32'd1) >= TIMEOUT);

endmodule

// File: rtl/soc_network_adapter_bus_bridge.sv
// Wishbone slave front-end forwarding single/burst beats to NREG register slaves.
// Optional ACCESS watchdog enabled by defining SOC_NETWORK_ADAPTER_BRIDGE_TIMEOUT_EN.
module soc_network_adapter_bus_bridge
  import soc_network_adapter_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned NREG    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic [2:0]         wb_cti_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [NREG-1:0]    s_sel,
  output logic [15:0]        s_adr,
  output logic               s_we,
  output logic [DW-1:0]      s_data_o,
  input  logic [NREG*DW-1:0] s_data_i,
  input  logic [NREG-1:0]    s_ack,
  input  logic [NREG-1:0]    s_rty,
  input  logic [NREG-1:0]    s_err
);

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_region;
  logic [1:0]    w_region_next;
  logic          r_ack;
  logic          r_err;
  logic          r_rty;
  logic          w_ack_n;
  logic          w_err_n;
  logic          w_rty_n;
  logic          w_cap;
  logic [DW-1:0] r_dat;

  logic          w_req;
  logic [1:0]    w_adr_region;
  logic          w_in_range;
  logic          w_sel_ack;
  logic          w_sel_err;
  logic          w_sel_rty;
  logic [DW-1:0] w_sel_data;
  logic          w_expired;
  logic          w_timeout;
  logic          w_unused;

  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_adr_region = region_of(wb_adr_i[15:0]);
  assign w_in_range   = 32'(w_adr_region) < NREG;
  assign w_unused     = ^wb_adr_i[31:16];

  // Loop-based select keeps out-of-range region values from indexing past NREG.
  always_comb begin
    w_sel_ack  = 1'b0;
    w_sel_err  = 1'b0;
    w_sel_rty  = 1'b0;
    w_sel_data = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (r_region == 2'(r)) begin
        w_sel_ack  = s_ack[r];
        w_sel_err  = s_err[r];
        w_sel_rty  = s_rty[r];
        w_sel_data = s_data_i[r*DW +: DW];
      end
    end
  end

`ifdef SOC_NETWORK_ADAPTER_BRIDGE_TIMEOUT_EN
  soc_network_adapter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != ACCESS),
    .i_enable ((r_state == ACCESS) && wb_cyc_i),
    .o_expired(w_expired)
  );
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT);
  assign w_expired        = 1'b0;
`endif

  assign w_timeout = w_expired & ~(w_sel_ack | w_sel_err | w_sel_rty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_region <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rty    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_state  <= w_next;
      r_region <= w_region_next;
      r_ack    <= w_ack_n;
      r_err    <= w_err_n;
      r_rty    <= w_rty_n;
      if (w_cap) begin
        r_dat <= w_sel_data;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_region_next = r_region;
    w_ack_n       = 1'b0;
    w_err_n       = 1'b0;
    w_rty_n       = 1'b0;
    w_cap         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_region_next = w_adr_region;
          if (w_in_range) begin
            w_next = ACCESS;
          end else begin
            w_next  = RESP;
            w_err_n = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          w_next = IDLE;
        end else if (w_sel_err) begin
          w_next  = RESP;
          w_err_n = 1'b1;
        end else if (w_sel_rty) begin
          w_next  = RESP;
          w_rty_n = 1'b1;
        end else if (w_sel_ack) begin
          w_next  = RESP;
          w_ack_n = 1'b1;
          w_cap   = 1'b1;
        end else if (w_timeout) begin
          w_next  = RESP;
          w_err_n = 1'b1;
        end
      end
      RESP: begin
        // Burst continuation re-decodes from the address the master presents now.
        if ((wb_cti_i == CTI_INCR) && w_req) begin
          w_region_next = w_adr_region;
          if (w_in_range) begin
            w_next = ACCESS;
          end else begin
            w_next  = RESP;
            w_err_n = 1'b1;
          end
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_sel = '0;
    if ((r_state == ACCESS) && wb_cyc_i && !w_timeout) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r_region == 2'(r)) begin
          s_sel[r] = 1'b1;
        end
      end
    end
  end

  assign s_we     = wb_we_i & (s_sel != '0);
  assign s_adr    = wb_adr_i[15:0];
  assign s_data_o = wb_dat_i;
  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = r_rty;

endmodule

// File: tb/tb_soc_network_adapter_bus_bridge.sv
// Self-checking bench for soc_network_adapter_bus_bridge: directed and random
// Wishbone transfers checked against a cycle-level expectation model.
module tb_soc_network_adapter_bus_bridge;

  localparam int DW   = 32;
  localparam int NREG = 3;
  localparam int TOUT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_we_i;
  logic [31:0]        wb_adr_i;
  logic [DW-1:0]      wb_dat_i;
  logic [2:0]         wb_cti_i;
  logic [DW-1:0]      wb_dat_o;
  logic               wb_ack_o;
  logic               wb_err_o;
  logic               wb_rty_o;
  logic [NREG-1:0]    s_sel;
  logic [15:0]        s_adr;
  logic               s_we;
  logic [DW-1:0]      s_data_o;
  logic [NREG*DW-1:0] s_data_i;
  logic [NREG-1:0]    s_ack;
  logic [NREG-1:0]    s_rty;
  logic [NREG-1:0]    s_err;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_dat;

  always #5 clk = ~clk;

  soc_network_adapter_bus_bridge #(
    .DW     (DW),
    .NREG   (NREG),
    .TIMEOUT(TOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_cti_i(wb_cti_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o),
    .s_sel   (s_sel),
    .s_adr   (s_adr),
    .s_we    (s_we),
    .s_data_o(s_data_o),
    .s_data_i(s_data_i),
    .s_ack   (s_ack),
    .s_rty   (s_rty),
    .s_err   (s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic a, input logic e, input logic r);
    chk({tag, "_ack"}, 64'(wb_ack_o), 64'(a));
    chk({tag, "_err"}, 64'(wb_err_o), 64'(e));
    chk({tag, "_rty"}, 64'(wb_rty_o), 64'(r));
  endtask

  task automatic clear_slaves();
    s_ack = '0;
    s_err = '0;
    s_rty = '0;
  endtask

  // One beat from its decode cycle to its response cycle; rsp = {err,rty,ack}.
  task automatic beat(input logic [31:0] adr, input logic we, input logic [DW-1:0] wdat,
                      input logic [2:0] cti, input int waits, input logic [2:0] rsp,
                      input logic [DW-1:0] rdat, input bit first);
    int            r;
    logic [DW-1:0] rd;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = wdat;
    wb_cti_i = first ? cti : 3'b010;
    if (first) begin
      #1;
      chk("idle_sel", 64'(s_sel), 64'd0);
    end
    tick();
    wb_cti_i = cti;
    r = int'(adr[15:14]);
    if (r >= NREG) begin
      strobes("oor", 1'b0, 1'b1, 1'b0);
      chk("oor_sel", 64'(s_sel), 64'd0);
      chk("oor_dat", 64'(wb_dat_o), 64'(exp_dat));
      return;
    end
    rd = '0;
    for (int k = 0; k <= waits; k++) begin
      for (int j = 0; j < NREG; j++) s_data_i[j*DW +: DW] = $urandom;
      s_data_i[r*DW +: DW] = rdat;
      s_ack = NREG'($urandom);
      s_err = NREG'($urandom);
      s_rty = NREG'($urandom);
      s_ack[r] = (k == waits) & rsp[0];
      s_rty[r] = (k == waits) & rsp[1];
      s_err[r] = (k == waits) & rsp[2];
      #1;
      chk("acc_sel", 64'(s_sel), 64'(1) << r);
      chk("acc_we", 64'(s_we), 64'(we));
      chk("acc_adr", 64'(s_adr), 64'(adr[15:0]));
      chk("acc_wdat", 64'(s_data_o), 64'(wdat));
      strobes("acc", 1'b0, 1'b0, 1'b0);
      rd = rdat;
      tick();
    end
    clear_slaves();
    if (rsp[2]) begin
      strobes("rsp_e", 1'b0, 1'b1, 1'b0);
    end else if (rsp[1]) begin
      strobes("rsp_r", 1'b0, 1'b0, 1'b1);
    end else begin
      strobes("rsp_a", 1'b1, 1'b0, 1'b0);
      exp_dat = rd;
    end
    chk("rsp_dat", 64'(wb_dat_o), 64'(exp_dat));
    chk("rsp_sel", 64'(s_sel), 64'd0);
  endtask

  task automatic end_xfer(input logic [2:0] cti);
    wb_cti_i = cti;
    tick();
    wb_stb_i = 1'b0;
    #1;
    chk("end_sel", 64'(s_sel), 64'd0);
    strobes("end", 1'b0, 1'b0, 1'b0);
    tick();
    wb_cyc_i = 1'b0;
  endtask

  initial begin
    int            nb;
    int            reg_i;
    logic [31:0]   adr;
    logic [2:0]    cti;
    logic [2:0]    rsp;

    rst      = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_cti_i = 3'b000;
    s_data_i = '0;
    clear_slaves();
    exp_dat  = '0;
    repeat (2) @(posedge clk);
    #1;
    strobes("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_we", 64'(s_we), 64'd0);
    chk("rst_dat", 64'(wb_dat_o), 64'd0);
    rst = 1'b0;
    wb_cyc_i = 1'b0;
    tick();

    // classic read, slave 0 combinational ack with 0x10
    beat(32'h0000_0004, 1'b0, $urandom, 3'b000, 0, 3'b001, 32'h10, 1'b1);
    chk("t1_dat", 64'(wb_dat_o), 64'h10);
    end_xfer(3'b000);

    // write, slave 1 with 3 wait states
    beat(32'h0000_4000, 1'b1, 32'hA5A5_1234, 3'b000, 3, 3'b001, 32'hDEAD_BEEF, 1'b1);
    end_xfer(3'b000);

    // out-of-range region 3
    beat(32'h0000_C000, 1'b0, $urandom, 3'b000, 0, 3'b001, '0, 1'b1);
    end_xfer(3'b000);

    // 4-beat incrementing burst
    for (int i = 0; i < 4; i++) begin
      beat(32'h0000_0200 + 32'(4 * i), 1'b0, $urandom, (i < 3) ? 3'b010 : 3'b111, 0,
           3'b001, $urandom, i == 0);
    end
    end_xfer(3'b111);

    // simultaneous responses: err beats ack, rty beats ack
    beat(32'h0000_0010, 1'b0, $urandom, 3'b000, 1, 3'b101, $urandom, 1'b1);
    end_xfer(3'b000);
    beat(32'h0000_8010, 1'b0, $urandom, 3'b000, 0, 3'b011, $urandom, 1'b1);
    end_xfer(3'b000);

    // master drops cyc in the 2nd ACCESS cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0000_4010;
    wb_cti_i = 3'b000;
    tick();
    chk("abt_sel1", 64'(s_sel), 64'b010);
    tick();
    wb_cyc_i = 1'b0;
    #1;
    chk("abt_sel2", 64'(s_sel), 64'd0);
    chk("abt_we", 64'(s_we), 64'd0);
    tick();
    strobes("abt", 1'b0, 1'b0, 1'b0);
    chk("abt_dat", 64'(wb_dat_o), 64'(exp_dat));
    wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
    #1;
    chk("abt_idle", 64'(s_sel), 64'd0);
    tick();
    wb_cyc_i = 1'b0;
    tick();

    // silent slave 2
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_8000;
    tick();
`ifdef SOC_NETWORK_ADAPTER_BRIDGE_TIMEOUT_EN
    for (int k = 0; k < TOUT; k++) begin
      chk("wd_sel", 64'(s_sel), (k < TOUT - 1) ? 64'b100 : 64'd0);
      strobes("wd_wait", 1'b0, 1'b0, 1'b0);
      tick();
    end
    strobes("wd", 1'b0, 1'b1, 1'b0);
    end_xfer(3'b000);
`else
    for (int k = 0; k < 3 * TOUT; k++) begin
      chk("hold_sel", 64'(s_sel), 64'b100);
      strobes("hold", 1'b0, 1'b0, 1'b0);
      tick();
    end
    wb_cyc_i = 1'b0;
    tick();
    strobes("hold_abt", 1'b0, 1'b0, 1'b0);
    tick();
`endif

    // asynchronous reset in ACCESS
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0000_4000;
    tick();
    chk("ra_sel", 64'(s_sel), 64'b010);
    #2;
    rst = 1'b1;
    #1;
    chk("ra_sel0", 64'(s_sel), 64'd0);
    chk("ra_we0", 64'(s_we), 64'd0);
    strobes("ra", 1'b0, 1'b0, 1'b0);
    chk("ra_dat", 64'(wb_dat_o), 64'd0);
    exp_dat = '0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    #2;
    rst = 1'b0;
    tick();

    // random single and burst transfers
    for (int t = 0; t < 30; t++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        reg_i = $urandom_range(0, 3);
        adr = $urandom;
        adr[15:14] = 2'(reg_i);
        cti = (nb == 1) ? 3'b000 : ((i < nb - 1) ? 3'b010 : 3'b111);
        rsp = 3'($urandom_range(1, 7));
        beat(adr, 1'($urandom), $urandom, cti, $urandom_range(0, 3), rsp, $urandom, i == 0);
      end
      end_xfer((nb == 1) ? 3'b000 : 3'b111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
